// File: rtl/seqdet_prog.sv
`default_nettype none
// ============================================================================
// Module   : seqdet_prog
// Brief    : Run-time programmable serial sequence detector with a per-bit
//            don't-care mask and selectable overlapping detection. Optional
//            saturating match counter built when SEQDET_COUNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module seqdet_prog #(
    parameter int unsigned    W       = 8,
    parameter logic [W-1:0]   PATTERN = 8'h58,
    parameter int unsigned    CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      in,
    input  logic                      load,
    input  logic [W-1:0]              pat_in,
    input  logic [W-1:0]              mask_in,
    input  logic                      overlap,
    output logic                      out,
    output logic [$clog2(W+1)-1:0]    fill,
    output logic [CNT_W-1:0]          count
);

    localparam int unsigned   FW     = $clog2(W + 1);
    localparam logic [FW-1:0] C_FULL = FW'(W);

    typedef enum logic [0:0] {
        ST_FILLING = 1'b0,
        ST_ARMED   = 1'b1
    } state_t;

    logic [W-1:0]  r_sh;
    logic [W-1:0]  r_pat;
    logic [W-1:0]  r_mask;
    logic [FW-1:0] r_fill;
    logic          r_out;

    logic [W-1:0]  w_sh_n;
    logic [W-1:0]  w_pat_n;
    logic [W-1:0]  w_mask_n;
    logic [FW-1:0] w_fill_n;
    logic          w_out_n;

    state_t        w_state;
    logic [W-1:0]  w_sh_shift;
    logic [FW-1:0] w_fill_inc;
    logic          w_match;

    // The fill level is the state register; ARMED simply means a full window.
    assign w_state    = (r_fill == C_FULL) ? ST_ARMED : ST_FILLING;
    assign w_sh_shift = {r_sh[W-2:0], in};
    assign w_fill_inc = (w_state == ST_ARMED) ? C_FULL : r_fill + FW'(1);
    assign w_match    = (w_fill_inc == C_FULL) &&
                        (((w_sh_shift ^ r_pat) & r_mask) == '0);

    always_comb begin
        w_sh_n   = r_sh;
        w_pat_n  = r_pat;
        w_mask_n = r_mask;
        w_fill_n = r_fill;
        w_out_n  = 1'b0;
        if (load) begin
            w_pat_n  = pat_in;
            w_mask_n = mask_in;
            w_fill_n = '0;
        end else if (en) begin
            w_sh_n  = w_sh_shift;
            w_out_n = w_match;
            // Non-overlapping mode invalidates the window after every hit.
            w_fill_n = (w_match && !overlap) ? '0 : w_fill_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh   <= '0;
            r_pat  <= PATTERN;
            r_mask <= '1;
            r_fill <= '0;
            r_out  <= 1'b0;
        end else begin
            r_sh   <= w_sh_n;
            r_pat  <= w_pat_n;
            r_mask <= w_mask_n;
            r_fill <= w_fill_n;
            r_out  <= w_out_n;
        end
    end

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_n;

    always_comb begin
        w_count_n = r_count;
        if (load) begin
            w_count_n = '0;
        end else if (en && w_match && (r_count != '1)) begin
            w_count_n = r_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_n;
        end
    end

    assign count = r_count;
`else
    assign count = '0;
`endif

    assign out  = r_out;
    assign fill = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_seqdet_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_seqdet_prog
// Brief    : Directed self-checking bench for seqdet_prog (W=8), with a second
//            CNT_W=2 instance sharing the stimulus for counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seqdet_prog;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       din;
    logic       load;
    logic       overlap;
    logic [7:0] pat_in;
    logic [7:0] mask_in;

    logic       out8;
    logic [3:0] fill8;
    logic [7:0] count8;
    logic       out2;
    logic [3:0] fill2;
    logic [1:0] count2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seqdet_prog #(.W(8), .PATTERN(8'h58), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .in(din), .load(load),
        .pat_in(pat_in), .mask_in(mask_in), .overlap(overlap),
        .out(out8), .fill(fill8), .count(count8)
    );

    seqdet_prog #(.W(8), .PATTERN(8'h58), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .in(din), .load(load),
        .pat_in(pat_in), .mask_in(mask_in), .overlap(overlap),
        .out(out2), .fill(fill2), .count(count2)
    );

    function automatic int cexp(input int v);
`ifdef SEQDET_COUNT_EN
        return v;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b);
        en  = 1'b1;
        din = b;
        tick();
        en  = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] p, input logic [7:0] m);
        load    = 1'b1;
        pat_in  = p;
        mask_in = m;
        tick();
        load    = 1'b0;
    endtask

    initial begin
        logic [7:0] v;
        rst = 1'b1; en = 1'b0; din = 1'b0; load = 1'b0; overlap = 1'b1;
        pat_in = '0; mask_in = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_out", out8, 0);
        chk("reset_fill", fill8, 0);
        chk("reset_count", count8, 0);
        chk("reset_count2", count2, 0);

        // Default pattern 0x58, first bit is the MSB
        v = 8'h58;
        for (int i = 0; i < 8; i++) begin
            send(v[7-i]);
            chk("def_out", out8, (i == 7));
            chk("def_fill", fill8, i + 1);
        end
        chk("def_count", count8, cexp(1));
        tick();
        chk("def_pulse_end", out8, 0);
        chk("def_fill_hold", fill8, 8);

        // Overlapping detection of 0x55
        overlap = 1'b1;
        do_load(8'h55, 8'hFF);
        chk("load_fill", fill8, 0);
        chk("load_count", count8, 0);
        for (int i = 1; i <= 10; i++) begin
            send(i % 2 == 0);
            chk("ov1_out", out8, (i == 8 || i == 10));
        end
        chk("ov1_count", count8, cexp(2));
        chk("ov1_fill", fill8, 8);

        // Non-overlapping detection of 0x55
        overlap = 1'b0;
        do_load(8'h55, 8'hFF);
        for (int i = 1; i <= 10; i++) begin
            send(i % 2 == 0);
            chk("ov0_out", out8, (i == 8));
        end
        chk("ov0_count", count8, cexp(1));
        chk("ov0_fill", fill8, 2);

        // Masked compare: only the low nibble 1000 matters
        overlap = 1'b1;
        do_load(8'h08, 8'h0F);
        v = 8'hF8;
        for (int i = 0; i < 8; i++) begin
            send(v[7-i]);
            chk("mask_out", out8, (i == 7));
        end
        chk("mask_count", count8, cexp(1));

        // Enable gap between bits 4 and 5
        do_load(8'h58, 8'hFF);
        v = 8'h58;
        for (int i = 0; i < 4; i++) send(v[7-i]);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("gap_out", out8, 0);
            chk("gap_fill", fill8, 4);
        end
        for (int i = 4; i < 8; i++) begin
            send(v[7-i]);
            chk("gap_match_out", out8, (i == 7));
        end
        chk("gap_count", count8, cexp(1));

        // Reset after bit 5 discards the partial match
        for (int i = 0; i < 5; i++) send(v[7-i]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_fill", fill8, 0);
        chk("rst_count", count8, 0);
        for (int i = 5; i < 8; i++) begin
            send(v[7-i]);
            chk("rst_out", out8, 0);
        end
        chk("rst_fill_end", fill8, 3);

        // Mask of zero: every bit matches once armed; CNT_W=2 saturates at 3
        overlap = 1'b1;
        do_load(8'h00, 8'h00);
        for (int i = 1; i <= 12; i++) begin
            send(i[0]);
            chk("sat_out", out2, (i >= 8));
            chk("sat_count2", count2, cexp((i < 8) ? 0 : ((i - 7) > 3 ? 3 : (i - 7))));
        end
        chk("sat_count8", count8, cexp(5));

        // Load wins over a simultaneous enabled bit
        load = 1'b1; en = 1'b1; din = 1'b1;
        pat_in = 8'h58; mask_in = 8'hFF;
        tick();
        load = 1'b0; en = 1'b0;
        chk("ldpri_fill", fill8, 0);
        chk("ldpri_count", count8, 0);
        chk("ldpri_count2", count2, 0);
        chk("ldpri_out", out8, 0);
        v = 8'h58;
        for (int i = 0; i < 8; i++) begin
            send(v[7-i]);
            chk("ldpri_match", out8, (i == 7));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seqdet_prog.md
# seqdet_prog

Parametrised, run-time programmable serial sequence detector. It is the successor to the fixed 0x58 detector. A one-bit serial stream is sampled on each enabled clock and compared against a W-bit pattern with a per-bit don't-care mask. `out` pulses on every match, with overlapping or non-overlapping detection selectable. The block sits behind the `clkrst` clock/reset generator and feeds downstream control logic with the match pulse and an optional match count.

## Interface
- `W`, 8: pattern length in bits, minimum 2.
- `PATTERN`, 8'h58: pattern loaded at reset. Bit W-1 is the first bit received.
- `CNT_W`, 8: match counter width.
- `clk  in  1`: clock, rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `en  in  1`: sample `in` this cycle.
- `in  in  1`: serial data bit.
- `load  in  1`: latch `pat_in` and `mask_in`, restart detection.
- `pat_in  in  W`: new pattern.
- `mask_in  in  W`: new mask. 1 means compare the bit, 0 means don't-care.
- `overlap  in  1`: 1 = overlapping detection, 0 = non-overlapping.
- `out  out  1`: registered one-cycle match pulse.
- `fill  out  $clog2(W+1)`: number of valid bits currently in the window.
- `count  out  CNT_W`: saturating match count.

## Operation
- Registers: shift window `sh[W-1:0]`, `pat`, `mask`, `fill`, `out`, `count`.
- Reset values: `sh`=0, `pat`=PATTERN, `mask`=all ones, `fill`=0, `out`=0, `count`=0.
- FSM, derived from `fill`:
  - FILLING when `fill`<W.
  - ARMED when `fill`==W.
- Enabled cycle (`en`=1, `load`=0):
  - `sh_n` = {sh[W-2:0], in}.
  - `fill_n` = min(fill+1, W).
  - match = (`fill_n`==W) && (((sh_n ^ pat) & mask) == 0).
  - `out` <= match.
- On a match:
  - `overlap`=1: `fill` stays W (ARMED), so the next bit can complete a new match.
  - `overlap`=0: `fill` <= 0 (back to FILLING). `sh` still shifts, but its contents are invalid until W more bits arrive.
  - `count` <= `count`+1, saturating at 2^CNT_W-1.
- `en`=0: `sh`, `fill` and `count` hold; `out` <= 0. Gaps in `en` never break a partial match.
- `load`=1:
  - `pat` <= `pat_in`, `mask` <= `mask_in`.
  - `fill` <= 0, `count` <= 0, `out` <= 0.
  - `in` and `en` are ignored that cycle.
- Priority: `rst` > `load` > `en`.
- `mask`=0 is legal. Once ARMED, every enabled bit matches (overlap) or every W-th bit matches (non-overlap).
- `overlap` is sampled on the enabled cycle that produces a match. Changing it mid-stream is legal and affects only subsequent matches.

## Timing
- `out` is high the cycle after the edge that samples the W-th matching bit. It is a single-cycle pulse per match.
- `count` and `fill` update on the same edge as `out`.
- A new pattern takes effect on the bit sampled the cycle after `load`.
- First match after reset or `load` needs at least W enabled samples.
- `rst` mid-sequence discards all partial history at the next edge.

## Configuration
- Macro: `SEQDET_COUNT_EN`.
- Defined: the `count` register and saturating increment are built as described above.
- Undefined: no counter flops are built and `count` is tied to 0. All other behaviour is identical.

## Test plan
All scenarios use W=8 unless stated.
- **Default pattern:** reset, then stream 0,1,0,1,1,0,0,0 with `en`=1 → `out`=1 for exactly one cycle after the 8th bit, `count`=1, `fill`=8.
- **Overlap mode:** `load` `pat_in`=8'h55, `mask_in`=8'hFF, then stream 0,1 repeated for 10 bits.
  - `overlap`=1 → pulses after bits 8 and 10, `count`=2.
  - `overlap`=0 → pulse after bit 8 only, `count`=1, `fill`=2 at the end.
- **Mask:** `load` `pat_in`=8'h08, `mask_in`=8'h0F, stream 1,1,1,1,1,0,0,0 → match after bit 8, `count`=1.
- **Enable gaps and reset:**
  - Default pattern with `en`=0 for 3 cycles between bits 4 and 5 → one match, `out` low during the gap.
  - Assert `rst` after bit 5, then send the remaining 3 bits → no match, `fill`=3.
- **Saturation:** CNT_W=2, `mask_in`=0, `overlap`=1, stream 12 bits → first match after bit 8, `count` sticks at 3.
- **Load priority:** `load`=1 with `en`=1 and `in`=1 in the same cycle → bit ignored, `fill`=0, `count`=0.
